// File: rtl/ppfifo_pattern_gen.sv
// Ping-pong FIFO pattern generator: writes increment, walking-one, fill or
// LFSR words into round-robin granted FIFO channels in size-limited bursts.
// Ports: clk, rst (async active-low), enable, mode, fill, write_count,
//   throttle, ready[CH], activate[CH], fifo_size, fifo_data, strobe,
//   busy, finished, words_sent.
module ppfifo_pattern_gen #(
  parameter int          DATA_WIDTH = 32,
  parameter int          SIZE_WIDTH = 24,
  parameter int          CHANNELS   = 2,
  parameter logic [31:0] LFSR_SEED  = 32'h0000_0001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] fill,
  input  logic [SIZE_WIDTH-1:0] write_count,
  input  logic                  throttle,
  input  logic [CHANNELS-1:0]   ready,
  output logic [CHANNELS-1:0]   activate,
  input  logic [SIZE_WIDTH-1:0] fifo_size,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  strobe,
  output logic                  busy,
  output logic                  finished,
  output logic [SIZE_WIDTH-1:0] words_sent
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Galois taps for x^32+x^22+x^2+x+1, right-shifting form
  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACQ,
    S_WRITE,
    S_REL,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [1:0]            r_mode;
  logic [DATA_WIDTH-1:0] r_fill;
  logic [DATA_WIDTH-1:0] r_pat;
  logic [31:0]           r_lfsr;
  logic [SIZE_WIDTH-1:0] r_remain;
  logic [SIZE_WIDTH-1:0] r_burst;
  logic [SIZE_WIDTH-1:0] r_words;
  logic                  r_first;
  logic                  r_gap;
  logic [CW-1:0]         r_last;
  logic [CHANNELS-1:0]   r_act;
  logic                  r_stb;
  logic [DATA_WIDTH-1:0] r_data;

  logic [DATA_WIDTH-1:0] w_lfsr_w;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_found;
  logic [CW-1:0]         w_grant;
  logic [CHANNELS-1:0]   w_grant_oh;

  generate
    if (DATA_WIDTH > 32) begin : g_lfsr_ext
      assign w_lfsr_w = {{(DATA_WIDTH-32){1'b0}}, r_lfsr};
    end else if (DATA_WIDTH == 32) begin : g_lfsr_eq
      assign w_lfsr_w = r_lfsr;
    end else begin : g_lfsr_trunc
      assign w_lfsr_w = r_lfsr[DATA_WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    w_word = r_pat;
    unique case (r_mode)
      2'd2:    w_word = r_fill;
      2'd3:    w_word = w_lfsr_w;
      default: w_word = r_pat;
    endcase
  end

  // Round-robin search starting one past the last granted channel
  always_comb begin
    int j;
    j          = 0;
    w_found    = 1'b0;
    w_grant    = r_last;
    w_grant_oh = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      j = int'(r_last) + i;
      if (j >= CHANNELS) j = j - CHANNELS;
      if (!w_found && ready[CW'(j)]) begin
        w_found = 1'b1;
        w_grant = CW'(j);
      end
    end
    w_grant_oh[w_grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_mode   <= 2'd0;
      r_fill   <= '0;
      r_pat    <= '0;
      r_lfsr   <= LFSR_SEED;
      r_remain <= '0;
      r_burst  <= '0;
      r_words  <= '0;
      r_first  <= 1'b0;
      r_gap    <= 1'b0;
      r_last   <= CW'(CHANNELS-1);
      r_act    <= '0;
      r_stb    <= 1'b0;
      r_data   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_act <= '0;
          r_stb <= 1'b0;
          if (enable) begin
            r_mode   <= mode;
            r_fill   <= fill;
            r_remain <= write_count;
            r_pat    <= (mode == 2'd1) ?
                        DATA_WIDTH'(1) : '0;
            r_lfsr   <= LFSR_SEED;
            r_words  <= '0;
            r_state  <= (write_count == '0) ?
                        S_DONE : S_ACQ;
          end
        end
        S_ACQ: begin
          if (!enable) begin
            r_act   <= '0;
            r_stb   <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_found) begin
            r_act   <= w_grant_oh;
            r_last  <= w_grant;
            r_first <= 1'b1;
            r_gap   <= 1'b0;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!enable) begin
            r_act   <= '0;
            r_stb   <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_first) begin
            r_first <= 1'b0;
            r_burst <= (fifo_size < r_remain) ?
                       fifo_size : r_remain;
          end else if (r_burst == '0) begin
            // strobe and activate fall together so no
            // word is ever presented without ownership
            r_stb   <= 1'b0;
            r_act   <= '0;
            r_state <= S_REL;
          end else if (r_gap) begin
            r_stb <= 1'b0;
            r_gap <= 1'b0;
          end else begin
            r_stb    <= 1'b1;
            r_data   <= w_word;
            r_burst  <= r_burst - 1'b1;
            r_remain <= r_remain - 1'b1;
            r_words  <= r_words + 1'b1;
            r_gap    <= throttle;
            unique case (r_mode)
              2'd0: r_pat <= r_pat + 1'b1;
              2'd1: r_pat <= {r_pat[DATA_WIDTH-2:0],
                              r_pat[DATA_WIDTH-1]};
              2'd3: r_lfsr <= r_lfsr[0] ?
                              ((r_lfsr >> 1) ^ TAPS) :
                              (r_lfsr >> 1);
              default: r_pat <= r_pat;
            endcase
          end
        end
        S_REL: begin
          r_stb <= 1'b0;
          r_act <= '0;
          if (!enable) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= (r_remain == '0) ?
                       S_DONE : S_ACQ;
          end
        end
        S_DONE: begin
          r_stb <= 1'b0;
          r_act <= '0;
          if (!enable) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign activate   = r_act;
  assign strobe     = r_stb;
  assign fifo_data  = r_data;
  assign words_sent = r_words;
  assign busy       = (r_state == S_ACQ) ||
                      (r_state == S_WRITE) ||
                      (r_state == S_REL);
  assign finished   = (r_state == S_DONE);

endmodule

// File: tb/tb_ppfifo_pattern_gen.sv
// Directed bench for ppfifo_pattern_gen: vector table of complete runs
// plus hand sequences for abort, reset, zero-size and 8-bit wrap.
module tb_ppfifo_pattern_gen;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [31:0] fill;
  logic [23:0] write_count;
  logic        throttle;
  logic [1:0]  ready;
  logic [1:0]  activate;
  logic [23:0] fifo_size;
  logic [31:0] fifo_data;
  logic        strobe;
  logic        busy;
  logic        finished;
  logic [23:0] words_sent;

  logic [1:0]  activate8;
  logic [7:0]  fifo_data8;
  logic        strobe8;
  logic        busy8;
  logic        finished8;
  logic [23:0] words_sent8;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit act_seen;

  logic [31:0] q_d[$];
  logic [1:0]  q_a[$];
  int          q_c[$];
  logic [7:0]  q8[$];

  ppfifo_pattern_gen u_dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .fill(fill), .write_count(write_count),
    .throttle(throttle), .ready(ready),
    .activate(activate), .fifo_size(fifo_size),
    .fifo_data(fifo_data), .strobe(strobe), .busy(busy),
    .finished(finished), .words_sent(words_sent)
  );

  ppfifo_pattern_gen #(.DATA_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .fill(fill[7:0]), .write_count(write_count),
    .throttle(throttle), .ready(ready),
    .activate(activate8), .fifo_size(fifo_size),
    .fifo_data(fifo_data8), .strobe(strobe8), .busy(busy8),
    .finished(finished8), .words_sent(words_sent8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (activate != 2'b00) act_seen = 1'b1;
    if (strobe8) q8.push_back(fifo_data8);
    if (strobe) begin
      q_d.push_back(fifo_data);
      q_a.push_back(activate);
      q_c.push_back(cyc);
      n_cmp++;
      if (activate == 2'b00) begin
        n_bad++;
        $display("FAIL strobe_without_activate: got %b required nonzero",
                 activate);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  task automatic clr_q();
    q_d.delete();
    q_a.delete();
    q_c.delete();
    q8.delete();
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rst    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clr_q();
  endtask

  task automatic wait_done(input int maxc);
    int k;
    k = 0;
    while (!finished && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk("finished_within_bound", finished, 1);
  endtask

  task automatic wait_words(input int n, input int maxc);
    int k;
    k = 0;
    while (int'(words_sent) != n && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk("words_reached", words_sent, n);
  endtask

  typedef struct packed {
    logic [1:0]        mode;
    logic [31:0]       fill;
    logic [23:0]       cnt;
    logic [23:0]       fsz;
    logic              thr;
    logic [9:0][31:0]  d;
    logic [9:0][1:0]   ch;
  } vec_t;

  vec_t vt[5];

  initial begin
    rst = 1'b0; enable = 1'b0; mode = 2'd0; fill = '0;
    write_count = '0; throttle = 1'b0; ready = 2'b11;
    fifo_size = '0;

    vt[0] = '0;
    vt[0].mode = 2'd0; vt[0].cnt = 10; vt[0].fsz = 4;
    for (int i = 0; i < 10; i++) begin
      vt[0].d[i]  = i;
      vt[0].ch[i] = (i >= 4 && i < 8) ? 2'b10 : 2'b01;
    end

    vt[1] = '0;
    vt[1].mode = 2'd3; vt[1].cnt = 3; vt[1].fsz = 16;
    vt[1].d[0] = 32'h0000_0001;
    vt[1].d[1] = 32'h8020_0003;
    vt[1].d[2] = 32'hC030_0002;
    for (int i = 0; i < 3; i++) vt[1].ch[i] = 2'b01;

    vt[2] = '0;
    vt[2].mode = 2'd2; vt[2].fill = 32'hA5A5_A5A5;
    vt[2].cnt = 4; vt[2].fsz = 8; vt[2].thr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vt[2].d[i]  = 32'hA5A5_A5A5;
      vt[2].ch[i] = 2'b01;
    end

    vt[3] = '0;
    vt[3].mode = 2'd1; vt[3].cnt = 5; vt[3].fsz = 2;
    vt[3].d[0] = 32'h1; vt[3].d[1] = 32'h2; vt[3].d[2] = 32'h4;
    vt[3].d[3] = 32'h8; vt[3].d[4] = 32'h10;
    vt[3].ch[0] = 2'b01; vt[3].ch[1] = 2'b01;
    vt[3].ch[2] = 2'b10; vt[3].ch[3] = 2'b10;
    vt[3].ch[4] = 2'b01;

    vt[4] = '0;
    vt[4].mode = 2'd0; vt[4].cnt = 6; vt[4].fsz = 3;
    vt[4].thr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vt[4].d[i]  = i;
      vt[4].ch[i] = (i < 3) ? 2'b01 : 2'b10;
    end

    // reset state
    #1;
    chk("rst_activate", activate, 0);
    chk("rst_strobe", strobe, 0);
    chk("rst_fifo_data", fifo_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_finished", finished, 0);
    chk("rst_words_sent", words_sent, 0);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      mode        = vt[v].mode;
      fill        = vt[v].fill;
      write_count = vt[v].cnt;
      fifo_size   = vt[v].fsz;
      throttle    = vt[v].thr;
      ready       = 2'b11;
      enable      = 1'b1;
      wait_done(400);
      chk($sformatf("v%0d_words_sent", v), words_sent, vt[v].cnt);
      chk($sformatf("v%0d_busy_done", v), busy, 0);
      chk($sformatf("v%0d_nwords", v), q_d.size(), vt[v].cnt);
      for (int i = 0; i < int'(vt[v].cnt) && i < q_d.size(); i++) begin
        chk($sformatf("v%0d_data%0d", v, i), q_d[i], vt[v].d[i]);
        chk($sformatf("v%0d_chan%0d", v, i), q_a[i], vt[v].ch[i]);
        if (vt[v].thr && i > 0 && q_a[i] == q_a[i-1])
          chk($sformatf("v%0d_gap%0d", v, i),
              q_c[i] - q_c[i-1], 2);
      end
      enable = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_finished_clear", v), finished, 0);
    end

    // 8-bit walking one wraps from bit 7 back to bit 0
    do_reset();
    mode = 2'd1; write_count = 9; fifo_size = 16;
    throttle = 1'b0; ready = 2'b11; enable = 1'b1;
    wait_done(400);
    chk("walk8_n", q8.size(), 9);
    for (int i = 0; i < 9 && i < q8.size(); i++) begin
      logic [7:0] e;
      e = 8'h01 << (i % 8);
      chk($sformatf("walk8_d%0d", i), q8[i], e);
    end
    enable = 1'b0;
    @(negedge clk);

    // abort after 5 of 20 words
    do_reset();
    mode = 2'd0; write_count = 20; fifo_size = 32;
    enable = 1'b1;
    wait_words(5, 200);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_activate", activate, 0);
    chk("abort_strobe", strobe, 0);
    chk("abort_finished", finished, 0);
    chk("abort_busy", busy, 0);
    chk("abort_words_sent", words_sent, 5);
    repeat (5) @(negedge clk);
    chk("abort_nwords", q_d.size(), 5);

    // asynchronous reset in the middle of a burst
    do_reset();
    mode = 2'd0; write_count = 20; fifo_size = 32;
    enable = 1'b1;
    wait_words(3, 200);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_activate", activate, 0);
    chk("mid_rst_strobe", strobe, 0);
    chk("mid_rst_fifo_data", fifo_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_words_sent", words_sent, 0);
    enable = 1'b0;
    @(negedge clk);
    clr_q();
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_no_strobe", q_d.size(), 0);

    // zero-length run
    do_reset();
    act_seen = 1'b0;
    write_count = 0; fifo_size = 4; enable = 1'b1;
    repeat (4) @(negedge clk);
    chk("zero_finished", finished, 1);
    chk("zero_busy", busy, 0);
    chk("zero_no_activate", act_seen, 0);
    chk("zero_no_strobe", q_d.size(), 0);
    enable = 1'b0;
    @(negedge clk);

    // no ready, then empty bursts from fifo_size 0
    do_reset();
    ready = 2'b00; mode = 2'd0; write_count = 3;
    fifo_size = 0; enable = 1'b1;
    repeat (4) @(negedge clk);
    chk("noready_busy", busy, 1);
    chk("noready_activate", activate, 0);
    act_seen = 1'b0;
    ready = 2'b10;
    repeat (12) @(negedge clk);
    chk("fsz0_granted", act_seen, 1);
    chk("fsz0_no_strobe", q_d.size(), 0);
    chk("fsz0_words_sent", words_sent, 0);
    chk("fsz0_finished", finished, 0);
    fifo_size = 3;
    wait_done(100);
    chk("fsz3_nwords", q_d.size(), 3);
    chk("fsz3_words_sent", words_sent, 3);
    if (q_a.size() > 0) chk("fsz3_chan", q_a[0], 2'b10);
    else chk("fsz3_chan_present", q_a.size(), 1);
    enable = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1);
  end

endmodule
